// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// One access in flight; read data returned with a one-cycle valid strobe.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_we,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic              busy
);

  // state | meaning
  // IDLE  | sample requests, pick winner, latch its command
  // CMD   | drive RAM command for the latched access, pulse owner gnt
  // RESP  | return ram_dataOut to the owner with rvalid

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q;      // 0 = A, 1 = B
  logic                last_gnt_q;   // 0 = A, 1 = B
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
  logic                any_req;
  logic                win_b;

  assign any_req = a_req | b_req;
  // With both requesting, the side not granted last time wins.
  assign win_b   = (a_req & b_req) ? ~last_gnt_q : b_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q    <= win_b;
        last_gnt_q <= win_b;
        wr_q       <= win_b ? b_wr : a_wr;
        addr_q     <= win_b ? b_addr : a_addr;
        wdata_q    <= win_b ? b_wdata : a_wdata;
      end
      if (state_q == RESP) begin
        if (owner_q) b_rdata_q <= ram_dataOut;
        else         a_rdata_q <= ram_dataOut;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    a_rvalid    = 1'b0;
    b_rvalid    = 1'b0;
    a_rdata     = a_rdata_q;
    b_rdata     = b_rdata_q;
    ram_address = addr_q;
    ram_dataIn  = wdata_q;
    ram_we      = 1'b0;
    ram_rd      = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) state_d = CMD;
      end
      CMD: begin
        a_gnt   = ~owner_q;
        b_gnt   = owner_q;
        ram_we  = wr_q;
        ram_rd  = ~wr_q;
        state_d = wr_q ? IDLE : RESP;
      end
      RESP: begin
        // A reset landing here aborts the access, so the strobe is suppressed.
        if (owner_q) begin
          b_rvalid = ~reset;
          b_rdata  = ram_dataOut;
        end else begin
          a_rvalid = ~reset;
          a_rdata  = ram_dataOut;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 RAM attached.
module tb_ram_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       a_req, a_wr, b_req, b_wr;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [3:0] ram_address;
  logic [7:0] ram_dataIn;
  logic       ram_we, ram_rd;
  logic [7:0] ram_dataOut = 8'h00;
  logic       busy;

  logic [7:0] mem [16];
  int total = 0;
  int bad = 0;
  logic [7:0] ea, eb;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_dataOut(ram_dataOut),
    .busy(busy)
  );

  always @(posedge clock) begin
    if (ram_we) mem[ram_address] <= ram_dataIn;
    if (ram_rd) ram_dataOut <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      chk("gnt_onehot", {31'd0, a_gnt & b_gnt}, 0);
      chk("we_rd_onehot", {31'd0, ram_we & ram_rd}, 0);
      if (!busy) chk("idle_cmd_off", {31'd0, ram_we | ram_rd}, 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_cmd", {ram_we, ram_rd}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    reset = 1'b0;
    ea = 8'h00;
    eb = 8'h00;
  endtask

  // Single-requester access; called just after a posedge with the DUT idle.
  task automatic txn(input bit port, input bit wr, input logic [3:0] addr, input logic [7:0] data);
    if (!port) begin a_req = 1; a_wr = wr; a_addr = addr; a_wdata = data; end
    else       begin b_req = 1; b_wr = wr; b_addr = addr; b_wdata = data; end
    step();
    chk("txn_gnt", {a_gnt, b_gnt}, port ? 2'b01 : 2'b10);
    chk("txn_busy", busy, 1);
    chk("txn_we", ram_we, wr);
    chk("txn_rd", ram_rd, !wr);
    chk("txn_addr", ram_address, addr);
    if (wr) chk("txn_wdata", ram_dataIn, data);
    a_req = 0;
    b_req = 0;
    step();
    if (!wr) begin
      chk("txn_rvalid", {a_rvalid, b_rvalid}, port ? 2'b01 : 2'b10);
      if (!port) begin
        chk("txn_a_rdata", a_rdata, data);
        chk("txn_b_hold", b_rdata, eb);
        ea = data;
      end else begin
        chk("txn_b_rdata", b_rdata, data);
        chk("txn_a_hold", a_rdata, ea);
        eb = data;
      end
      step();
    end else begin
      chk("txn_wr_norvalid", {a_rvalid, b_rvalid}, 0);
    end
    chk("txn_idle", busy, 0);
  endtask

  typedef struct {
    bit         port;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 1, 4'd3,  8'hA5};
    tbl[1] = '{0, 0, 4'd3,  8'hA5};
    tbl[2] = '{1, 1, 4'd15, 8'hFF};
    tbl[3] = '{1, 0, 4'd15, 8'hFF};
    tbl[4] = '{0, 1, 4'd0,  8'h5A};
    tbl[5] = '{1, 0, 4'd0,  8'h5A};
    tbl[6] = '{0, 0, 4'd15, 8'hFF};
    tbl[7] = '{1, 1, 4'd7,  8'h3C};
    tbl[8] = '{0, 0, 4'd7,  8'h3C};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset = 1; a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    do_reset();

    for (int i = 0; i < 9; i++) txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].data);

    // Simultaneous reads straight after reset: A first, then B.
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 4'd3;
    b_req = 1; b_wr = 0; b_addr = 4'd15;
    step();
    chk("both_first_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 0;
    step();
    chk("both_a_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    chk("both_a_rdata", a_rdata, 8'hA5);
    chk("both_b_rdata_hold", b_rdata, 8'h00);
    step();
    chk("both_gap_idle", {busy, a_gnt, b_gnt}, 0);
    step();
    chk("both_second_gnt", {a_gnt, b_gnt}, 2'b01);
    chk("both_second_addr", ram_address, 4'd15);
    b_req = 0;
    step();
    chk("both_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
    chk("both_b_rdata", b_rdata, 8'hFF);
    chk("both_a_rdata_hold", a_rdata, 8'hA5);
    ea = 8'hA5; eb = 8'hFF;
    step();
    chk("both_end_idle", busy, 0);

    // Continuous competing writes alternate A,B,A,B.
    a_req = 1; a_wr = 1; a_addr = 4'd1; a_wdata = 8'h11;
    b_req = 1; b_wr = 1; b_addr = 4'd2; b_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_gnt", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_addr", ram_address, (i % 2 == 0) ? 4'd1 : 4'd2);
      chk("rr_we", ram_we, 1);
      if (i == 3) begin a_req = 0; b_req = 0; end
      step();
      chk("rr_idle", busy, 0);
    end
    txn(0, 0, 4'd1, 8'h11);
    txn(1, 0, 4'd2, 8'h22);

    // Reset during RESP of an A read drops the pending strobe.
    a_req = 1; a_wr = 0; a_addr = 4'd3;
    step();
    chk("rst_mid_gnt", a_gnt, 1);
    a_req = 0;
    step();
    chk("rst_mid_in_resp", busy, 1);
    reset = 1;
    step();
    chk("rst_mid_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt0", {a_gnt, b_gnt}, 0);
    chk("rst_mid_rdata", a_rdata, 8'h00);
    reset = 0;
    ea = 8'h00; eb = 8'h00;
    txn(0, 0, 4'd3, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
